video_timing_generator: RTL

VIDEO_TIMING_GENERATOR -- requirements
Module: video_timing_generator

---
 rtl/video_timing_generator.sv | 85 ++++++++
 1 files changed

// File: rtl/video_timing_generator.sv
// Raster timing generator: free-running h/v counters with registered, skew-free
// coordinate, blanking and sync outputs.
module video_timing_generator #(
    parameter int unsigned HOR_ACTIVE_PIXELS = 640,
    parameter int unsigned HOR_FRONT_PORCH   = 16,
    parameter int unsigned HOR_SYNC_PULSE    = 96,
    parameter int unsigned HOR_BACK_PORCH    = 48,
    parameter int unsigned VER_ACTIVE_PIXELS = 480,
    parameter int unsigned VER_FRONT_PORCH   = 10,
    parameter int unsigned VER_SYNC_PULSE    = 2,
    parameter int unsigned VER_BACK_PORCH    = 33,
    parameter bit          HSYNC_ACTIVE_HIGH = 1'b0,
    parameter bit          VSYNC_ACTIVE_HIGH = 1'b0,
    localparam int unsigned X_WIDTH = $clog2(HOR_ACTIVE_PIXELS),
    localparam int unsigned Y_WIDTH = $clog2(VER_ACTIVE_PIXELS)
) (
    input  logic               clk,
    input  logic               rst,
    output logic [X_WIDTH-1:0] x,
    output logic [Y_WIDTH-1:0] y,
    output logic               active,
    output logic               hsync,
    output logic               vsync,
    output logic               frame_start
);

    localparam int unsigned H_TOTAL = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC_PULSE +
                                      HOR_BACK_PORCH;
    localparam int unsigned V_TOTAL = VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC_PULSE +
                                      VER_BACK_PORCH;
    localparam int unsigned H_WIDTH = $clog2(H_TOTAL);
    localparam int unsigned V_WIDTH = $clog2(V_TOTAL);

    localparam int unsigned H_SYNC_START = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + HOR_SYNC_PULSE;
    localparam int unsigned V_SYNC_START = VER_ACTIVE_PIXELS + VER_FRONT_PORCH;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + VER_SYNC_PULSE;

    localparam logic [H_WIDTH-1:0] H_LAST = H_WIDTH'(H_TOTAL - 1);
    localparam logic [V_WIDTH-1:0] V_LAST = V_WIDTH'(V_TOTAL - 1);

    logic [H_WIDTH-1:0] h_q, h_d;
    logic [V_WIDTH-1:0] v_q, v_d;
    logic               h_wrap, v_wrap;
    logic               h_act, v_act, h_in_sync, v_in_sync;

    always_comb begin
        h_wrap    = (h_q == H_LAST);
        v_wrap    = (v_q == V_LAST);
        h_d       = h_wrap ? '0 : h_q + H_WIDTH'(1);
        v_d       = v_q;
        if (h_wrap) begin
            v_d = v_wrap ? '0 : v_q + V_WIDTH'(1);
        end
        h_act     = (32'(h_q) < HOR_ACTIVE_PIXELS);
        v_act     = (32'(v_q) < VER_ACTIVE_PIXELS);
        h_in_sync = (32'(h_q) >= H_SYNC_START) && (32'(h_q) < H_SYNC_END);
        v_in_sync = (32'(v_q) >= V_SYNC_START) && (32'(v_q) < V_SYNC_END);
    end

    // Outputs are decoded from the pre-edge counter value, so every output
    // describes the same (h,v) and the first edge after reset shows (0,0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q         <= '0;
            v_q         <= '0;
            x           <= '0;
            y           <= '0;
            active      <= 1'b0;
            frame_start <= 1'b0;
            hsync       <= ~HSYNC_ACTIVE_HIGH;
            vsync       <= ~VSYNC_ACTIVE_HIGH;
        end else begin
            h_q         <= h_d;
            v_q         <= v_d;
            x           <= h_act ? h_q[X_WIDTH-1:0] : '0;
            y           <= v_act ? v_q[Y_WIDTH-1:0] : '0;
            active      <= h_act && v_act;
            frame_start <= (h_q == '0) && (v_q == '0);
            hsync       <= h_in_sync ? HSYNC_ACTIVE_HIGH : ~HSYNC_ACTIVE_HIGH;
            vsync       <= v_in_sync ? VSYNC_ACTIVE_HIGH : ~VSYNC_ACTIVE_HIGH;
        end
    end

endmodule
